// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the LEGv8 multi-cycle fetch stage.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;
  localparam int INST_W = 32;
  localparam logic [10:0] OPC_HALT = 11'h7FF;
  localparam int B_IMM_LSB = 0;
  localparam int B_IMM_MSB = 25;
  localparam int CB_IMM_LSB = 5;
  localparam int CB_IMM_MSB = 23;
endpackage

// File: rtl/cpu_next_pc.sv
// cpu_next_pc: branch decision and next-PC arithmetic from the latched instruction immediates.
module cpu_next_pc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [B_IMM_MSB:0] imm,
  input  logic               branch,
  input  logic               branch_zero,
  input  logic               branch_nonzero,
  input  logic               alu_zero,
  output logic [ADDR_W-1:0]  next_pc
);
  localparam int BW = B_IMM_MSB - B_IMM_LSB + 1;
  localparam int CW = CB_IMM_MSB - CB_IMM_LSB + 1;
  logic [ADDR_W-1:0] b_off, cb_off;
  logic taken;
  assign b_off = {{(ADDR_W-BW-2){imm[B_IMM_MSB]}}, imm[B_IMM_MSB:B_IMM_LSB], 2'b00};
  assign cb_off = {{(ADDR_W-CW-2){imm[CB_IMM_MSB]}}, imm[CB_IMM_MSB:CB_IMM_LSB], 2'b00};
  assign taken = branch | (branch_zero & alu_zero) | (branch_nonzero & ~alu_zero);
  // Unconditional branch offset wins when several flags are raised together.
  assign next_pc = pc + (taken ? (branch ? b_off : cb_off) : ADDR_W'(4));
endmodule

// File: rtl/cpu_fetch.sv
// cpu_fetch: owns the PC, fetches instructions over req/ack and holds each one
// until execute reports completion; stops for good on HALT.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  input  logic              exec_done,
  input  logic              branch,
  input  logic              branch_zero,
  input  logic              branch_nonzero,
  input  logic              alu_zero,
  output logic              halted
);
  state_t state, state_n;
  logic [ADDR_W-1:0] next_pc;
  logic is_halt, accept, retire;
  assign is_halt = inst[31:21] == OPC_HALT;
  assign accept = state == FETCH && imem_ack;
  assign retire = state == ISSUE && exec_done;
  assign imem_addr = pc;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? FETCH :
              accept        ? ISSUE :
              retire        ? (is_halt ? HALTED : FETCH) : state;
  end
  always_comb begin
    imem_req = state == FETCH;
    inst_valid = state == ISSUE;
    halted = state == HALTED;
  end
  always_ff @(posedge clk)
    if (reset) begin
      pc <= RESET_PC;
      inst <= '0;
    end else begin
      if (accept) inst <= imem_rdata;
      if (retire && !is_halt) pc <= next_pc;
    end
  cpu_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc(pc),
    .imm(inst[B_IMM_MSB:0]),
    .branch(branch),
    .branch_zero(branch_zero),
    .branch_nonzero(branch_nonzero),
    .alu_zero(alu_zero),
    .next_pc(next_pc)
  );
endmodule

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
- Instruction-fetch stage of the LEGv8 multi-cycle CPU, directly upstream of cpu_control.
- Owns the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents the instruction, whose bits [31:21] drive cpu_control, and waits for execute to report completion.
- Uses the branch controls and ALU zero flag from execute to compute the next PC; stops permanently on HALT.

Parameters:
- ADDR_W, 64, PC and instruction-address width.
- RESET_PC, 64'h0, PC value loaded on reset; must be word aligned.

Ports:
- clk  in  1  Single system clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- imem_req  out  1  Fetch request to instruction memory.
- imem_addr  out  ADDR_W  Fetch address; equals pc.
- imem_rdata  in  32  Instruction word; valid when imem_ack=1.
- imem_ack  in  1  Memory response strobe.
- inst  out  32  Latched instruction to decode; bits [31:21] go to cpu_control.
- inst_valid  out  1  inst holds a fetched, not-yet-executed instruction.
- pc  out  ADDR_W  Address of the current or next instruction.
- exec_done  in  1  One-cycle strobe: execute has finished the instruction in inst.
- branch  in  1  Unconditional branch (B), from cpu_control.
- branch_zero  in  1  CBZ, from cpu_control.
- branch_nonzero  in  1  CBNZ, from cpu_control.
- alu_zero  in  1  ALU zero flag for the current instruction.
- halted  out  1  HALT has retired; the core is stopped.

Behaviour:
- Reset (synchronous, wins over all other inputs):
  - pc=RESET_PC, inst=32'h0, inst_valid=0, imem_req=0, halted=0, state=IDLE.
- States: IDLE, FETCH, ISSUE, HALTED.
  - IDLE: one cycle after reset deasserts -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - Wait for imem_ack; there is no timeout. imem_ack is ignored when imem_req=0.
    - On ack: inst<=imem_rdata, inst_valid<=1, imem_req<=0, -> ISSUE.
    - Minimum fetch latency is 1 cycle: ack arriving in the first cycle req is high is accepted.
  - ISSUE: inst and pc are held stable; imem_req=0.
    - Wait for exec_done. On exec_done: inst_valid<=0 and pc<=next_pc.
    - If inst[31:21]==11'h7FF (HALT): -> HALTED, pc unchanged. Otherwise -> FETCH.
    - exec_done in any state other than ISSUE is ignored.
  - HALTED: halted=1, imem_req=0, inst_valid=0. Terminal until reset.
- Branch decision: taken = branch | (branch_zero & alu_zero) | (branch_nonzero & ~alu_zero). Sampled only on the exec_done cycle.
- Target offsets, computed from the latched inst:
  - branch=1: offset = sign-extend(inst[25:0]) << 2.
  - branch_zero or branch_nonzero: offset = sign-extend(inst[23:5]) << 2.
  - If several flags are set, branch has priority over conditional offsets.
- next_pc = taken ? pc + offset : pc + 4.
- PC arithmetic is modulo 2^ADDR_W; wrap-around is silent, e.g. pc=2^64-4 plus 4 gives 0.
- pc[1:0] is always 0. Unaligned RESET_PC is a configuration error and is not corrected.
- Reset mid-fetch (req outstanding): the request is dropped. A late imem_ack arriving in IDLE is ignored.
- exec_done and reset in the same cycle: reset wins; pc=RESET_PC.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum (IDLE/FETCH/ISSUE/HALTED);
  - OPC_HALT=11'h7FF;
  - INST_W=32;
  - the B/CB immediate field bit positions.
- One natural sub-module, cpu_next_pc (combinational): takes pc, inst and the branch controls with alu_zero; produces next_pc. This lets verification check it exhaustively in isolation.

Test Plan:
- Reset then sequential fetch: RESET_PC=0, ack after 2 cycles, word ADD, exec_done -> inst_valid=1 at pc=0; after exec_done, imem_addr=4 with imem_req=1.
- B backward: pc=0x40, inst=0x17FFFFFC (imm26=-4), branch=1 -> next imem_addr=0x30.
- CBZ both outcomes: pc=0x100, imm19=+3, branch_zero=1.
  - alu_zero=1 -> 0x10C.
  - alu_zero=0 -> 0x104.
  - Repeat with CBNZ: the outcomes swap.
- HALT: inst=0xFFE00000 fetched, exec_done -> halted=1, inst_valid=0, imem_req stays 0 for 20 cycles, pc unchanged.
- Reset mid-fetch: reset while imem_req=1, then stale imem_ack one cycle later -> inst_valid stays 0; fetch restarts at RESET_PC.
- Wrap and spurious strobes:
  - pc=64'hFFFF_FFFF_FFFF_FFFC, not taken -> next pc=0.
  - exec_done pulsed during FETCH -> no pc change.
